// File: rtl/flit_tx_if.sv
// rtl/flit_tx_if.sv - FIFO, allocator, link and credit signals of the flit transmitter
interface flit_tx_if #(
  parameter int FLIT_LENGTH = 32,
  parameter int CREDIT_W    = 3
);
  logic [FLIT_LENGTH-1:0] fifo_data_i;
  logic                   fifo_empty_i;
  logic                   fifo_pop_o;
  logic                   req_o;
  logic                   grant_i;
  logic                   link_valid_o;
  logic [FLIT_LENGTH-1:0] link_flit_o;
  logic                   credit_i;
  logic [CREDIT_W-1:0]    credit_o;
  logic                   err_o;

  // transmitter side
  modport slave (
    input  fifo_data_i, fifo_empty_i, grant_i, credit_i,
    output fifo_pop_o, req_o, link_valid_o, link_flit_o, credit_o, err_o
  );

  // environment side: FIFO, allocator and downstream router
  modport master (
    output fifo_data_i, fifo_empty_i, grant_i, credit_i,
    input  fifo_pop_o, req_o, link_valid_o, link_flit_o, credit_o, err_o
  );
endinterface

// File: rtl/flit_tx.sv
// rtl/flit_tx.sv - credit-based link transmitter draining a router input FIFO
module flit_tx #(
  parameter int FLIT_LENGTH = 32,
  parameter int CREDIT_MAX  = 4,
  parameter int CREDIT_W    = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  flit_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] LP_CREDIT_MAX = CREDIT_W'(CREDIT_MAX);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CREDIT_W-1:0]    r_credit;
  logic                   r_first;
  logic                   r_err;
  logic                   r_link_valid;
  logic [FLIT_LENGTH-1:0] r_link_flit;

  logic [1:0]             w_type;
  logic                   w_is_head;
  logic                   w_is_tail;
  logic                   w_send;
  logic                   w_orphan;
  logic                   w_dup_head;
  logic                   w_credit_ovf;

  // Flit type decode: head/single open a packet, tail/single close it
  assign w_type    = bus.fifo_data_i[FLIT_LENGTH-1 -: 2];
  assign w_is_head = (w_type == 2'b01) || (w_type == 2'b11);
  assign w_is_tail = (w_type == 2'b10) || (w_type == 2'b11);

  // Next-state logic plus the send/discard decisions that drive the pop strobe
  always_comb begin
    w_next_state = r_state;
    w_send       = 1'b0;
    w_orphan     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.fifo_empty_i) begin
          if (w_is_head) begin
            w_next_state = S_REQ;
          end else begin
            w_orphan = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus.grant_i) begin
          w_next_state = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.fifo_empty_i && (r_credit != '0)) begin
          w_send = 1'b1;
          if (w_is_tail) begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Protocol violations: a head inside a packet, or a credit beyond the downstream depth
  assign w_dup_head   = w_send && w_is_head && !r_first;
  assign w_credit_ovf = bus.credit_i && !w_send && (r_credit == LP_CREDIT_MAX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Marks the first flit after the grant, so a later head is recognised as misplaced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first <= 1'b0;
    end else if ((r_state == S_REQ) && bus.grant_i) begin
      r_first <= 1'b1;
    end else if (w_send) begin
      r_first <= 1'b0;
    end
  end

  // Link output register: flit captured on send, held through stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link_valid <= 1'b0;
      r_link_flit  <= '0;
    end else begin
      r_link_valid <= w_send;
      if (w_send) begin
        r_link_flit <= bus.fifo_data_i;
      end
    end
  end

  // Credit counter: send consumes, return refills, both cancel, saturates at depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit <= LP_CREDIT_MAX;
    end else begin
      case ({w_send, bus.credit_i})
        2'b10:   r_credit <= r_credit - 1'b1;
        2'b01:   if (r_credit != LP_CREDIT_MAX) r_credit <= r_credit + 1'b1;
        default: r_credit <= r_credit;
      endcase
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_orphan || w_dup_head || w_credit_ovf) begin
      r_err <= 1'b1;
    end
  end

  assign bus.fifo_pop_o   = w_send || w_orphan;
  assign bus.req_o        = (r_state == S_REQ) || (r_state == S_SEND);
  assign bus.link_valid_o = r_link_valid;
  assign bus.link_flit_o  = r_link_flit;
  assign bus.credit_o     = r_credit;
  assign bus.err_o        = r_err;

endmodule

// File: tb/tb_flit_tx.sv
// tb/tb_flit_tx.sv - directed vectors and corner-case sequences for flit_tx
module tb_flit_tx;

  logic clk;
  logic rst_n;

  flit_tx_if #(.FLIT_LENGTH(32), .CREDIT_W(3)) bus();

  flit_tx #(.FLIT_LENGTH(32), .CREDIT_MAX(4), .CREDIT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: pushed by the stimulus, popped by the DUT, flushed by reset
  logic [31:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  assign bus.fifo_empty_i = (rd_ptr == wr_ptr);
  assign bus.fifo_data_i  = mem[rd_ptr % 64];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_pop_o && (rd_ptr != wr_ptr)) begin
      rd_ptr <= rd_ptr + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] f);
    mem[wr_ptr % 64] = f;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic drive(input logic g, input logic c);
    bus.grant_i  = g;
    bus.credit_i = c;
    #1;
  endtask

  task automatic nxt(input logic g, input logic c);
    @(negedge clk);
    drive(g, c);
  endtask

  task automatic do_reset();
    bus.grant_i  = 1'b0;
    bus.credit_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        g;
    logic        c;
    logic        req;
    logic        pop;
    logic        v;
    logic [31:0] f;
    logic [2:0]  cr;
    logic        e;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // 4-flit packet, grant right after req, then credit returns and one spurious credit
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'd4, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 3'd4, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 3'd4, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4000_00A1, 3'd3, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00B1, 3'd2, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00B2, 3'd1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_00C1, 3'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_00C1, 3'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_00C1, 3'd1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_00C1, 3'd2, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_00C1, 3'd3, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_00C1, 3'd4, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_00C1, 3'd4, 1'b1};

    bus.grant_i  = 1'b0;
    bus.credit_i = 1'b0;
    rst_n        = 1'b0;
    do_reset();

    // ---- table: full packet, credit refill, spurious credit ----
    push(32'h4000_00A1);
    push(32'h0000_00B1);
    push(32'h0000_00B2);
    push(32'h8000_00C1);
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clk);
      drive(tbl[i].g, tbl[i].c);
      chk($sformatf("tbl%0d_req", i),   32'(bus.req_o),        32'(tbl[i].req));
      chk($sformatf("tbl%0d_pop", i),   32'(bus.fifo_pop_o),   32'(tbl[i].pop));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.link_valid_o), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_flit", i),  bus.link_flit_o,       tbl[i].f);
      chk($sformatf("tbl%0d_credit", i), 32'(bus.credit_o),    32'(tbl[i].cr));
      chk($sformatf("tbl%0d_err", i),   32'(bus.err_o),        32'(tbl[i].e));
    end

    // ---- 6-flit packet: stall at zero credit, one credit releases one flit ----
    do_reset();
    push(32'h4000_0011);
    for (int k = 0; k < 4; k++) push(32'h0000_0012 + k);
    push(32'h8000_0016);
    drive(1'b0, 1'b0);
    nxt(1'b1, 1'b0);
    chk("stall_req_c1", 32'(bus.req_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      nxt(1'b0, 1'b0);
      chk($sformatf("stall_pop_c%0d", k + 2), 32'(bus.fifo_pop_o), 32'd1);
    end
    nxt(1'b0, 1'b0);
    chk("stall_credit0", 32'(bus.credit_o), 32'd0);
    chk("stall_pop0", 32'(bus.fifo_pop_o), 32'd0);
    chk("stall_last_flit", bus.link_flit_o, 32'h0000_0014);
    chk("stall_req_held", 32'(bus.req_o), 32'd1);
    nxt(1'b0, 1'b1);
    chk("stall_same_cycle_pop", 32'(bus.fifo_pop_o), 32'd0);
    chk("stall_valid0", 32'(bus.link_valid_o), 32'd0);
    chk("stall_flit_hold", bus.link_flit_o, 32'h0000_0014);
    nxt(1'b0, 1'b0);
    chk("refill_credit1", 32'(bus.credit_o), 32'd1);
    chk("refill_pop", 32'(bus.fifo_pop_o), 32'd1);
    nxt(1'b0, 1'b0);
    chk("refill_valid", 32'(bus.link_valid_o), 32'd1);
    chk("refill_flit", bus.link_flit_o, 32'h0000_0015);
    chk("refill_pop_again", 32'(bus.fifo_pop_o), 32'd0);
    chk("refill_credit0", 32'(bus.credit_o), 32'd0);

    // ---- send and credit return together for 10 cycles ----
    do_reset();
    push(32'h4000_0021);
    for (int k = 0; k < 12; k++) push(32'h0000_0100 + k);
    drive(1'b0, 1'b0);
    nxt(1'b1, 1'b0);
    nxt(1'b0, 1'b0);
    chk("ovl_first_pop", 32'(bus.fifo_pop_o), 32'd1);
    for (int k = 0; k < 10; k++) begin
      nxt(1'b0, 1'b1);
      chk($sformatf("ovl_credit_%0d", k), 32'(bus.credit_o), 32'd3);
      chk($sformatf("ovl_pop_%0d", k), 32'(bus.fifo_pop_o), 32'd1);
    end
    chk("ovl_err", 32'(bus.err_o), 32'd0);

    // ---- delayed grant, then back-to-back single flits ----
    do_reset();
    push(32'hC000_0031);
    push(32'hC000_0032);
    drive(1'b0, 1'b0);
    chk("gd_req_c0", 32'(bus.req_o), 32'd0);
    for (int k = 0; k < 5; k++) begin
      nxt(1'b0, 1'b0);
      chk($sformatf("gd_req_wait%0d", k), 32'(bus.req_o), 32'd1);
      chk($sformatf("gd_pop_wait%0d", k), 32'(bus.fifo_pop_o), 32'd0);
    end
    nxt(1'b1, 1'b0);
    chk("gd_pop_grant_cycle", 32'(bus.fifo_pop_o), 32'd0);
    nxt(1'b0, 1'b0);
    chk("gd_pop_s1", 32'(bus.fifo_pop_o), 32'd1);
    nxt(1'b0, 1'b0);
    chk("gd_req_gap", 32'(bus.req_o), 32'd0);
    chk("gd_flit_s1", bus.link_flit_o, 32'hC000_0031);
    chk("gd_pop_gap", 32'(bus.fifo_pop_o), 32'd0);
    nxt(1'b1, 1'b0);
    chk("gd_req_s2", 32'(bus.req_o), 32'd1);
    nxt(1'b0, 1'b0);
    chk("gd_pop_s2", 32'(bus.fifo_pop_o), 32'd1);
    nxt(1'b0, 1'b0);
    chk("gd_flit_s2", bus.link_flit_o, 32'hC000_0032);
    chk("gd_credit", 32'(bus.credit_o), 32'd2);
    chk("gd_err", 32'(bus.err_o), 32'd0);

    // ---- orphan body, then asynchronous reset in the middle of a packet ----
    do_reset();
    push(32'h0000_0041);
    drive(1'b0, 1'b0);
    chk("orph_pop", 32'(bus.fifo_pop_o), 32'd1);
    chk("orph_req", 32'(bus.req_o), 32'd0);
    nxt(1'b0, 1'b0);
    chk("orph_err", 32'(bus.err_o), 32'd1);
    chk("orph_empty", 32'(bus.fifo_empty_i), 32'd1);
    chk("orph_not_sent", 32'(bus.link_valid_o), 32'd0);
    push(32'h4000_0042);
    push(32'h0000_0043);
    push(32'h8000_0044);
    nxt(1'b1, 1'b0);
    chk("rst_req_before", 32'(bus.req_o), 32'd1);
    nxt(1'b0, 1'b0);
    nxt(1'b0, 1'b0);
    chk("rst_valid_before", 32'(bus.link_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(bus.req_o), 32'd0);
    chk("rst_pop", 32'(bus.fifo_pop_o), 32'd0);
    chk("rst_valid", 32'(bus.link_valid_o), 32'd0);
    chk("rst_flit", bus.link_flit_o, 32'h0000_0000);
    chk("rst_credit", 32'(bus.credit_o), 32'd4);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
